fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write-side arbiter that shares one `fifo` instance (`WIDTH`-bit, `fifo_full`/`write`/`data_in` interface) between `N_REQ` producer lanes, e.g. parallel modular-multiplier result streams. It grants one lane at a time for bursts of up to `BURST` words and drives the FIFO write port directly. It honours `fifo_full` back-pressure with zero-cycle latency, so the FIFO can never overflow.

## Interface
Parameters:
- `WIDTH`, 32, data word width; must match the FIFO.
- `N_REQ`, 4, number of requesting lanes (≥1).
- `BURST`, 8, maximum words transferred per grant (≥1).
- Derived: `GNT_W = max(1, $clog2(N_REQ))`; `CNT_W = $clog2(BURST+1)`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  lane i has a word on offer.
- `req_data`  in  N_REQ*WIDTH  lane i word at `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  N_REQ  lane i word accepted this cycle when `req_valid[i] & req_ready[i]`.
- `fifo_write`  out  1  connects to FIFO `write`.
- `fifo_data_in`  out  WIDTH  connects to FIFO `data_in`.
- `fifo_full`  in  1  from FIFO.
- `grant_active`  out  1  a lane currently holds the grant.
- `grant_id`  out  GNT_W  index of the granted lane.
- `burst_count`  out  CNT_W  words transferred in the current grant.

## Operation
- States: IDLE, GRANT.
- IDLE: if any `req_valid` is set, pick the first set lane, searching from `(last_grant+1) mod N_REQ` upward with wrap. Register `grant_id` and `last_grant` to it, clear `burst_count`, and go to GRANT. No transfer occurs in IDLE.
- GRANT:
  - `req_ready[grant_id] = ~fifo_full & ~rst`; all other `req_ready` bits are 0.
  - `fifo_write = req_valid[grant_id] & req_ready[grant_id]`.
  - `fifo_data_in = req_data[grant_id]`. It is also driven in IDLE but is don't-care there.
- GRANT exits to IDLE when either:
  - a transfer occurs with `burst_count == BURST-1`, or
  - `req_valid[grant_id] == 0` in a GRANT cycle.
- Otherwise GRANT holds. `burst_count` increments on each transfer.
- `fifo_full` stalls the burst but never releases the grant. A stalled lane keeps the grant until the FIFO drains.
- A lane that drops valid loses the remainder of its burst. Its next request waits for its round-robin turn.
- Requests arriving mid-burst are ignored until the next IDLE.
- `N_REQ == 1`: `grant_id` is constant 0 and the same rules apply.
- `BURST == 1`: every transfer releases the grant.

## Timing
- Reset values: state IDLE, `grant_active` 0, `grant_id` 0, `burst_count` 0, `last_grant = N_REQ-1` (lane 0 has first priority), `req_ready` all 0, `fifo_write` 0.
- `rst` asserted mid-burst:
  - `req_ready` and `fifo_write` are forced 0 combinationally in that cycle.
  - Next cycle is IDLE with reset values.
  - No partial word is written.
- Arbitration latency: one cycle. A request in IDLE at cycle t allows its first transfer at t+1.
- Throughput under continuous requests: `BURST` words per `BURST+1` cycles (one IDLE bubble per grant).
- `req_ready` and `fifo_write` depend combinationally on `fifo_full`, `req_valid` and registered state only. There is no combinational path from `req_data` to any control output.
- `grant_active` is high exactly in GRANT. `grant_id` and `burst_count` are registered and hold their last values in IDLE.

## Structure
- Shared package `fifo_arb_pkg`:
  - `arb_state_t` enum {IDLE, GRANT};
  - function `gnt_w(n)` returning `max(1,$clog2(n))`.
- Sub-module `rr_priority_pick` (combinational):
  - inputs: `N_REQ`-bit request vector and start index;
  - outputs: found flag and winning index.
- `fifo_write_arbiter` holds the FSM, `last_grant`, `burst_count` and the data/ready muxes.
- The integration top instantiates `fifo` and `fifo_write_arbiter` side by side.

## Test plan
- **Reset priority.** After reset, drive `req_valid=4'b1111`.
  - Grants go to lanes 0,1,2,3,0 in order.
  - Each grant transfers exactly 8 words, followed by a 1-cycle IDLE bubble.
- **Early release.** Lane 2 alone offers 3 words, then drops valid.
  - 3 FIFO writes occur with `burst_count` 1,2,3.
  - Next cycle is IDLE and `grant_active` is 0.
- **Full stall.** Assert `fifo_full` for 5 cycles mid-burst on lane 1 after 4 words.
  - `fifo_write` and `req_ready` are 0 for those 5 cycles and the grant holds.
  - The remaining 4 words then write.
  - FIFO contents equal lane 1's sequence with no loss or duplication.
- **Wrap-around.** `last_grant=3` with only lanes 0 and 3 requesting → lane 0 wins. Next grant is lane 3.
- **Mid-burst reset.** Assert `rst` for 1 cycle during lane 2's 5th word.
  - That word is not written.
  - After reset, lane 0 is granted first even if lane 2 still requests alongside it.
- **Scoreboard soak.** Random valid/data on 4 lanes with random `fifo_full`, 10k cycles.
  - Per-lane FIFO order is preserved.
  - No write occurs while `fifo_full` is high.
  - No lane waits more than 3 grants.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of a lane index: at least one bit even for a single lane.
  function automatic int gnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: returns the first set request at or
// above i_start, wrapping to the lowest set request below i_start.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GNT_W = gnt_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GNT_W-1:0] i_start,
  output logic             o_found,
  output logic [GNT_W-1:0] o_idx
);

  logic             w_hi_found;
  logic [GNT_W-1:0] w_hi_idx;
  logic             w_lo_found;
  logic [GNT_W-1:0] w_lo_idx;

  // Scan downward so the lowest qualifying index in each half wins.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (i_req[j]) begin
        if (GNT_W'(j) >= i_start) begin
          w_hi_found = 1'b1;
          w_hi_idx   = GNT_W'(j);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = GNT_W'(j);
        end
      end
    end
    o_found = w_hi_found | w_lo_found;
    o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO write port between
// N_REQ producer lanes, granting bursts of up to BURST words.
//
// Handshake: lane i's word moves into the FIFO in a cycle where
// req_valid[i] & req_ready[i] is high. req_ready is only ever high for the
// granted lane, only in GRANT, and never while fifo_full or rst is high,
// so fifo_write can never fire into a full FIFO. Control outputs depend on
// fifo_full, req_valid and registered state only, never on req_data.
// grant_active is the FSM state (high exactly in GRANT).
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4,
  parameter int BURST = 8,
  parameter int GNT_W = gnt_w(N_REQ),
  parameter int CNT_W = $clog2(BURST + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   fifo_write,
  output logic [WIDTH-1:0]       fifo_data_in,
  input  logic                   fifo_full,
  output logic                   grant_active,
  output logic [GNT_W-1:0]       grant_id,
  output logic [CNT_W-1:0]       burst_count
);

  arb_state_t       r_state;
  logic [GNT_W-1:0] r_grant_id;
  logic [GNT_W-1:0] r_last_grant;
  logic [CNT_W-1:0] r_burst_count;

  logic             w_found;
  logic [GNT_W-1:0] w_pick;
  logic [GNT_W-1:0] w_start;
  logic             w_sel_valid;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_grant_ready;
  logic             w_xfer;
  logic             w_last_word;

  // Search starts one past the previous winner, wrapping at N_REQ.
  assign w_start = (r_last_grant == GNT_W'(N_REQ - 1)) ? '0 : r_last_grant + 1'b1;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .GNT_W (GNT_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  // Select the granted lane's valid/data and build the ready vector.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (r_grant_id == GNT_W'(j)) begin
        w_sel_valid = req_valid[j];
        w_sel_data  = req_data[j*WIDTH +: WIDTH];
      end
    end
    w_grant_ready = (r_state == GRANT) & ~fifo_full & ~rst;
    req_ready     = '0;
    for (int j = 0; j < N_REQ; j++) begin
      req_ready[j] = w_grant_ready & (r_grant_id == GNT_W'(j));
    end
    w_xfer      = w_grant_ready & w_sel_valid;
    w_last_word = (r_burst_count == CNT_W'(BURST - 1));
  end

  assign fifo_write   = w_xfer;
  assign fifo_data_in = w_sel_data;
  assign grant_active = (r_state == GRANT);
  assign grant_id     = r_grant_id;
  assign burst_count  = r_burst_count;

  // Grant FSM: arbitrate in IDLE, stream the burst in GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant_id    <= '0;
      r_last_grant  <= GNT_W'(N_REQ - 1);
      r_burst_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_id    <= w_pick;
            r_last_grant  <= w_pick;
            r_burst_count <= '0;
            r_state       <= GRANT;
          end
        end
        GRANT: begin
          if (w_xfer) begin
            r_burst_count <= r_burst_count + 1'b1;
            if (w_last_word) begin
              r_state <= IDLE;
            end
          end else if (!w_sel_valid) begin
            // Lane withdrew: it forfeits the rest of its burst.
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter (WIDTH=32, N_REQ=4, BURST=8).
module tb_fifo_write_arbiter;

  localparam int WIDTH = 32;
  localparam int N_REQ = 4;
  localparam int BURST = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   fifo_write;
  logic [WIDTH-1:0]       fifo_data_in;
  logic                   fifo_full;
  logic                   grant_active;
  logic [1:0]             grant_id;
  logic [3:0]             burst_count;

  fifo_write_arbiter #(
    .WIDTH (WIDTH),
    .N_REQ (N_REQ),
    .BURST (BURST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .burst_count  (burst_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- lane sources and scoreboard ----------------
  logic [WIDTH-1:0] lane_word [N_REQ];
  logic [WIDTH-1:0] lane_q [N_REQ][$];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_data[i*WIDTH +: WIDTH] = lane_word[i];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Values captured in the sampling phase of the last cycle.
  logic             s_write;
  logic [N_REQ-1:0] s_ready;
  logic [N_REQ-1:0] s_acc;
  int               s_wlane;

  // Round-robin wait tracking.
  logic             pend_arb;
  logic [N_REQ-1:0] arb_req;
  int               wait_cnt [N_REQ];
  int               wait_max;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] new_word(input int lane);
    return {8'(lane), 24'($urandom)};
  endfunction

  // Observe combinational outputs mid-cycle and score any FIFO write.
  task automatic sample();
    logic [WIDTH-1:0] exp_w;
    s_write = fifo_write;
    s_ready = req_ready;
    s_acc   = req_valid & req_ready;
    s_wlane = -1;
    check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    check("write_eq_hs", 32'(fifo_write), 32'(|(req_valid & req_ready)));
    if (fifo_full || rst) check("ready_blocked", 32'(req_ready), 32'd0);
    if (fifo_full) check("no_write_full", 32'(fifo_write), 32'd0);
    if (fifo_write) begin
      for (int i = 0; i < N_REQ; i++) if (req_ready[i]) s_wlane = i;
      check("write_has_lane", 32'(s_wlane >= 0), 32'd1);
      if (s_wlane >= 0) begin
        check("lane_q_size", 32'(lane_q[s_wlane].size()), 32'd1);
        if (lane_q[s_wlane].size() > 0) begin
          exp_w = lane_q[s_wlane].pop_front();
          check("data_order", fifo_data_in, exp_w);
        end
      end
    end
    pend_arb = 1'b0;
    if (!rst && !grant_active && |req_valid) begin
      pend_arb = 1'b1;
      arb_req  = req_valid;
    end
  endtask

  // After the edge: advance accepted lanes and account for arbitration.
  task automatic advance();
    for (int i = 0; i < N_REQ; i++) begin
      if (s_acc[i]) begin
        lane_word[i] = new_word(i);
        lane_q[i].push_back(lane_word[i]);
      end
    end
    if (pend_arb) begin
      check("arb_latency", 32'(grant_active), 32'd1);
      for (int i = 0; i < N_REQ; i++) begin
        if (arb_req[i] && (32'(grant_id) != 32'(i))) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > wait_max) wait_max = wait_cnt[i];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    advance();
  endtask

  // Stream n words from lane g, burst_count expected to run k0..k0+n-1.
  task automatic run_burst(input int g, input int n, input int k0);
    for (int k = 0; k < n; k++) begin
      step();
      check("burst_write", 32'(s_write), 32'd1);
      check("burst_lane", 32'(s_wlane), 32'(g));
      check("burst_count", 32'(burst_count), 32'(k0 + k));
    end
  endtask

  task automatic expect_grant(input int g);
    step();
    check("idle_no_write", 32'(s_write), 32'd0);
    check("grant_active", 32'(grant_active), 32'd1);
    check("grant_id", 32'(grant_id), 32'(g));
    check("burst_clear", 32'(burst_count), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  int order1 [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    wait_max  = 0;
    pend_arb  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      wait_cnt[i]  = 0;
      lane_word[i] = new_word(i);
      lane_q[i].push_back(lane_word[i]);
    end

    // Reset state.
    repeat (2) step();
    check("rst_active", 32'(grant_active), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_burst", 32'(burst_count), 32'd0);
    check("rst_write", 32'(s_write), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    step();
    check("idle_no_req", 32'(grant_active), 32'd0);

    // Reset priority: all lanes busy, full bursts with one-cycle bubbles.
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      expect_grant(order1[n]);
      run_burst(order1[n], BURST, 1);
      check("burst_release", 32'(grant_active), 32'd0);
    end
    req_valid = '0;
    step();

    // Early release: lane 2 offers three words then withdraws.
    req_valid = 4'b0100;
    expect_grant(2);
    run_burst(2, 3, 1);
    req_valid = '0;
    step();
    check("early_no_write", 32'(s_write), 32'd0);
    check("early_idle", 32'(grant_active), 32'd0);
    check("early_count_hold", 32'(burst_count), 32'd3);

    // Full stall on lane 1 after four words.
    req_valid = 4'b0010;
    expect_grant(1);
    run_burst(1, 4, 1);
    fifo_full = 1'b1;
    repeat (5) begin
      step();
      check("stall_write", 32'(s_write), 32'd0);
      check("stall_ready", 32'(s_ready), 32'd0);
      check("stall_hold", 32'(grant_active), 32'd1);
      check("stall_id", 32'(grant_id), 32'd1);
      check("stall_count", 32'(burst_count), 32'd4);
    end
    fifo_full = 1'b0;
    run_burst(1, 4, 5);
    check("stall_release", 32'(grant_active), 32'd0);
    req_valid = '0;
    step();

    // Wrap-around: lane 3 becomes last, then lanes 0 and 3 compete.
    req_valid = 4'b1000;
    expect_grant(3);
    run_burst(3, BURST, 1);
    req_valid = 4'b1001;
    expect_grant(0);
    run_burst(0, BURST, 1);
    expect_grant(3);
    run_burst(3, BURST, 1);
    req_valid = '0;
    step();

    // Mid-burst reset on lane 2's fifth word.
    req_valid = 4'b0100;
    expect_grant(2);
    run_burst(2, 4, 1);
    rst       = 1'b1;
    req_valid = 4'b0101;
    step();
    check("mrst_no_write", 32'(s_write), 32'd0);
    check("mrst_no_ready", 32'(s_ready), 32'd0);
    check("mrst_idle", 32'(grant_active), 32'd0);
    check("mrst_id", 32'(grant_id), 32'd0);
    check("mrst_count", 32'(burst_count), 32'd0);
    rst = 1'b0;
    expect_grant(0);
    req_valid = '0;
    step();
    check("mrst_drop", 32'(grant_active), 32'd0);
    step();

    // Random soak.
    wait_max = 0;
    for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N_REQ; i++) req_valid[i] = ($urandom_range(0, 4) != 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      step();
    end
    req_valid = '0;
    fifo_full = 1'b0;
    repeat (3) step();
    check("max_wait_le3", 32'(wait_max <= 3), 32'd1);
    for (int i = 0; i < N_REQ; i++) check("lane_q_final", 32'(lane_q[i].size()), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
